// File: rtl/fp_wb_queue_pkg.sv
// Shared FP writeback definitions: default widths, queue depth and the
// {addr, data} entry layout used by the writeback queue.
package fp_wb_queue_pkg;

    localparam int unsigned FP_DATA_WIDTH = 32;
    localparam int unsigned FP_ADDR_WIDTH = 5;
    localparam int unsigned FP_WB_DEPTH   = 4;

    // Queue entry at the default widths; modules with overridden widths
    // declare the same layout locally from their own parameters.
    typedef struct packed {
        logic [FP_ADDR_WIDTH-1:0] addr;
        logic [FP_DATA_WIDTH-1:0] data;
    } fp_wb_entry_t;

endpackage

// File: rtl/fp_wb_match.sv
// Youngest-match search of one read-port index against the occupied
// entries of the writeback queue (oldest at head, youngest at head+count-1).
module fp_wb_match
    import fp_wb_queue_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = FP_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = FP_ADDR_WIDTH,
    parameter int unsigned DEPTH      = FP_WB_DEPTH,
    parameter int unsigned PTR_W      = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0][ADDR_WIDTH-1:0] ent_addr,
    input  logic [DEPTH-1:0][DATA_WIDTH-1:0] ent_data,
    input  logic [PTR_W-1:0]                 head,
    input  logic [PTR_W:0]                   count,
    input  logic [ADDR_WIDTH-1:0]            addr,
    output logic                             pend,
    output logic [DATA_WIDTH-1:0]            fwd
);

    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] idx;

    // Walk from oldest to youngest so the last hit is the youngest entry.
    always_comb begin
        pend = 1'b0;
        fwd  = '0;
        idx  = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = head + PTR_W'(i);
            if ((CNT_W'(i) < count) && (ent_addr[idx] == addr)) begin
                pend = 1'b1;
                fwd  = ent_data[idx];
            end
        end
    end

endmodule

// File: rtl/fp_wb_queue.sv
// FP register-file writeback queue: merges FP-load and FPU results into a
// circular FIFO that retires one entry per cycle, with pending/forward
// lookup for two read ports. Loads have fixed priority over the FPU.
module fp_wb_queue
    import fp_wb_queue_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = FP_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = FP_ADDR_WIDTH,
    parameter int unsigned DEPTH      = FP_WB_DEPTH
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic                     ld_valid,
    input  logic [ADDR_WIDTH-1:0]    ld_addr,
    input  logic [DATA_WIDTH-1:0]    ld_data,
    output logic                     ld_ready,
    input  logic                     fpu_valid,
    input  logic [ADDR_WIDTH-1:0]    fpu_addr,
    input  logic [DATA_WIDTH-1:0]    fpu_data,
    output logic                     fpu_ready,
    output logic                     write_En,
    output logic [ADDR_WIDTH-1:0]    writeAddr,
    output logic [DATA_WIDTH-1:0]    data_in,
    input  logic [ADDR_WIDTH-1:0]    addr_A,
    input  logic [ADDR_WIDTH-1:0]    addr_B,
    output logic                     pend_A,
    output logic                     pend_B,
    output logic [DATA_WIDTH-1:0]    fwd_A,
    output logic [DATA_WIDTH-1:0]    fwd_B,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("fp_wb_queue: DEPTH must be a power of two, at least 2");
    end

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    entry_t                          mem [DEPTH];
    logic [DEPTH-1:0][ADDR_WIDTH-1:0] ent_addr;
    logic [DEPTH-1:0][DATA_WIDTH-1:0] ent_data;

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W-1:0] fpu_slot;
    logic [CNT_W-1:0] free;
    logic             pop;
    logic             ld_push;
    logic             fpu_push;

    // Handshake: free space counts the slot released by this cycle's pop.
    always_comb begin
        pop       = (count != '0);
        free      = CNT_W'(DEPTH) - count + CNT_W'(pop);
        ld_ready  = (free >= CNT_W'(1));
        fpu_ready = (free >= CNT_W'(2)) || ((free >= CNT_W'(1)) && !ld_valid);
        ld_push   = ld_valid && ld_ready;
        fpu_push  = fpu_valid && fpu_ready;
        // On a dual push the FPU result lands behind the load result.
        fpu_slot  = tail + PTR_W'(ld_push);
    end

    // Register-file write port: head entry, masked while the queue is empty.
    always_comb begin
        write_En  = pop;
        writeAddr = pop ? mem[head].addr : '0;
        data_in   = pop ? mem[head].data : '0;
    end

    // Pointer and occupancy state; in-flight entries are dropped on reset.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PTR_W'(pop);
            tail  <= tail + PTR_W'(ld_push) + PTR_W'(fpu_push);
            count <= count + CNT_W'(ld_push) + CNT_W'(fpu_push) - CNT_W'(pop);
        end
    end

    // Entry storage; never exposed while unoccupied, so it is not reset.
    always_ff @(posedge Clk) begin
        if (ld_push) begin
            mem[tail] <= '{addr: ld_addr, data: ld_data};
        end
        if (fpu_push) begin
            mem[fpu_slot] <= '{addr: fpu_addr, data: fpu_data};
        end
    end

    // Flatten storage for the per-port match units.
    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            ent_addr[i] = mem[i].addr;
            ent_data[i] = mem[i].data;
        end
    end

    fp_wb_match #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH),
        .PTR_W      (PTR_W)
    ) u_match_a (
        .ent_addr (ent_addr),
        .ent_data (ent_data),
        .head     (head),
        .count    (count),
        .addr     (addr_A),
        .pend     (pend_A),
        .fwd      (fwd_A)
    );

    fp_wb_match #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH),
        .PTR_W      (PTR_W)
    ) u_match_b (
        .ent_addr (ent_addr),
        .ent_data (ent_data),
        .head     (head),
        .count    (count),
        .addr     (addr_B),
        .pend     (pend_B),
        .fwd      (fwd_B)
    );

endmodule

// File: tb/tb_fp_wb_queue.sv
// Directed bench for fp_wb_queue at default parameters (DEPTH=4).
module tb_fp_wb_queue;

    logic        Clk;
    logic        Rst;
    logic        ld_valid;
    logic [4:0]  ld_addr;
    logic [31:0] ld_data;
    logic        ld_ready;
    logic        fpu_valid;
    logic [4:0]  fpu_addr;
    logic [31:0] fpu_data;
    logic        fpu_ready;
    logic        write_En;
    logic [4:0]  writeAddr;
    logic [31:0] data_in;
    logic [4:0]  addr_A;
    logic [4:0]  addr_B;
    logic        pend_A;
    logic        pend_B;
    logic [31:0] fwd_A;
    logic [31:0] fwd_B;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;

    fp_wb_queue #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (5),
        .DEPTH      (4)
    ) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .ld_valid  (ld_valid),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .ld_ready  (ld_ready),
        .fpu_valid (fpu_valid),
        .fpu_addr  (fpu_addr),
        .fpu_data  (fpu_data),
        .fpu_ready (fpu_ready),
        .write_En  (write_En),
        .writeAddr (writeAddr),
        .data_in   (data_in),
        .addr_A    (addr_A),
        .addr_B    (addr_B),
        .pend_A    (pend_A),
        .pend_B    (pend_B),
        .fwd_A     (fwd_A),
        .fwd_B     (fwd_B),
        .count     (count)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset;
        #2;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
        checks++; if (write_En !== 1'b0) begin errors++; $display("FAIL reset_wen got %b exp 0", write_En); end
        checks++; if (pend_A !== 1'b0 || pend_B !== 1'b0) begin errors++; $display("FAIL reset_pend got %b%b exp 00", pend_A, pend_B); end
        checks++; if (fwd_A !== 32'h0 || fwd_B !== 32'h0) begin errors++; $display("FAIL reset_fwd got %h %h exp 0 0", fwd_A, fwd_B); end
        checks++; if (ld_ready !== 1'b1 || fpu_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b%b exp 11", ld_ready, fpu_ready); end
        tick();
        Rst = 1'b0;
        tick();
        checks++; if (write_En !== 1'b0) begin errors++; $display("FAIL idle_wen got %b exp 0", write_En); end
    endtask

    task automatic test_single_load;
        ld_valid = 1'b1; ld_addr = 5'd3; ld_data = 32'h3F80_0000;
        #1;
        checks++; if (ld_ready !== 1'b1) begin errors++; $display("FAIL single_ldready got %b exp 1", ld_ready); end
        tick();
        ld_valid = 1'b0;
        checks++; if (write_En !== 1'b1 || writeAddr !== 5'd3 || data_in !== 32'h3F80_0000)
            begin errors++; $display("FAIL single_write got %b %0d %h exp 1 3 3f800000", write_En, writeAddr, data_in); end
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL single_count got %0d exp 1", count); end
        tick();
        checks++; if (write_En !== 1'b0 || count !== 3'd0) begin errors++; $display("FAIL single_done got %b %0d exp 0 0", write_En, count); end
    endtask

    task automatic test_dual_push;
        ld_valid = 1'b1;  ld_addr = 5'd1;  ld_data = 32'hA;
        fpu_valid = 1'b1; fpu_addr = 5'd2; fpu_data = 32'hB;
        #1;
        checks++; if (fpu_ready !== 1'b1) begin errors++; $display("FAIL dual_fpuready got %b exp 1", fpu_ready); end
        tick();
        ld_valid = 1'b0; fpu_valid = 1'b0;
        checks++; if (count !== 3'd2 || write_En !== 1'b1 || writeAddr !== 5'd1 || data_in !== 32'hA)
            begin errors++; $display("FAIL dual_first got %0d %b %0d %h exp 2 1 1 a", count, write_En, writeAddr, data_in); end
        tick();
        checks++; if (count !== 3'd1 || write_En !== 1'b1 || writeAddr !== 5'd2 || data_in !== 32'hB)
            begin errors++; $display("FAIL dual_second got %0d %b %0d %h exp 1 1 2 b", count, write_En, writeAddr, data_in); end
        tick();
        checks++; if (count !== 3'd0 || write_En !== 1'b0) begin errors++; $display("FAIL dual_done got %0d %b exp 0 0", count, write_En); end
    endtask

    task automatic test_fill;
        // L_k = (10+k, 0x100+k), F_k = (20+k, 0x200+k); F3/F4 are refused.
        logic [4:0]  exp_addr [8] = '{5'd10, 5'd20, 5'd11, 5'd21, 5'd12, 5'd22, 5'd13, 5'd14};
        logic [31:0] exp_data [8] = '{32'h100, 32'h200, 32'h101, 32'h201, 32'h102, 32'h202, 32'h103, 32'h104};
        logic [2:0]  exp_cnt  [9] = '{3'd2, 3'd3, 3'd4, 3'd4, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
        logic        exp_frdy [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        for (int k = 0; k < 9; k++) begin
            if (k < 5) begin
                ld_valid = 1'b1;  ld_addr = 5'(10 + k);  ld_data = 32'(256 + k);
                fpu_valid = 1'b1; fpu_addr = 5'(20 + k); fpu_data = 32'(512 + k);
                #1;
                checks++; if (ld_ready !== 1'b1 || fpu_ready !== exp_frdy[k])
                    begin errors++; $display("FAIL fill_ready[%0d] got %b%b exp 1%b", k, ld_ready, fpu_ready, exp_frdy[k]); end
            end else begin
                ld_valid = 1'b0; fpu_valid = 1'b0;
            end
            tick();
            checks++; if (count !== exp_cnt[k]) begin errors++; $display("FAIL fill_count[%0d] got %0d exp %0d", k, count, exp_cnt[k]); end
            if (k < 8) begin
                checks++; if (write_En !== 1'b1 || writeAddr !== exp_addr[k] || data_in !== exp_data[k])
                    begin errors++; $display("FAIL fill_write[%0d] got %b %0d %h exp 1 %0d %h", k, write_En, writeAddr, data_in, exp_addr[k], exp_data[k]); end
            end else begin
                checks++; if (write_En !== 1'b0) begin errors++; $display("FAIL fill_drained got %b exp 0", write_En); end
            end
        end
    endtask

    task automatic test_forward;
        ld_valid = 1'b1;  ld_addr = 5'd12; ld_data = 32'h55;
        fpu_valid = 1'b1; fpu_addr = 5'd5; fpu_data = 32'h1;
        tick();
        ld_addr = 5'd7; ld_data = 32'h2;
        fpu_addr = 5'd5; fpu_data = 32'h3;
        tick();
        ld_valid = 1'b0; fpu_valid = 1'b0;
        addr_A = 5'd5; addr_B = 5'd9;
        #1;
        // Queue now (5,1) (7,2) (5,3), head first.
        checks++; if (count !== 3'd3) begin errors++; $display("FAIL fwd_count got %0d exp 3", count); end
        checks++; if (pend_A !== 1'b1 || fwd_A !== 32'h3) begin errors++; $display("FAIL fwd_A_young got %b %h exp 1 3", pend_A, fwd_A); end
        checks++; if (pend_B !== 1'b0 || fwd_B !== 32'h0) begin errors++; $display("FAIL fwd_B_miss got %b %h exp 0 0", pend_B, fwd_B); end
        addr_B = 5'd7; #1;
        checks++; if (pend_B !== 1'b1 || fwd_B !== 32'h2) begin errors++; $display("FAIL fwd_B_mid got %b %h exp 1 2", pend_B, fwd_B); end
        addr_B = 5'd12; #1;
        checks++; if (pend_B !== 1'b0 || fwd_B !== 32'h0) begin errors++; $display("FAIL fwd_B_retired got %b %h exp 0 0", pend_B, fwd_B); end
        addr_B = 5'd7;
        tick();
        tick();
        // Only (5,3) left, sitting at the head.
        checks++; if (pend_A !== 1'b1 || fwd_A !== 32'h3) begin errors++; $display("FAIL fwd_A_head got %b %h exp 1 3", pend_A, fwd_A); end
        checks++; if (pend_B !== 1'b0 || fwd_B !== 32'h0) begin errors++; $display("FAIL fwd_B_gone got %b %h exp 0 0", pend_B, fwd_B); end
        tick();
        checks++; if (pend_A !== 1'b0 || fwd_A !== 32'h0) begin errors++; $display("FAIL fwd_A_empty got %b %h exp 0 0", pend_A, fwd_A); end
        // Register index 0 is an ordinary register.
        ld_valid = 1'b1; ld_addr = 5'd0; ld_data = 32'h77; addr_A = 5'd0;
        tick();
        ld_valid = 1'b0;
        checks++; if (pend_A !== 1'b1 || fwd_A !== 32'h77) begin errors++; $display("FAIL fwd_zero got %b %h exp 1 77", pend_A, fwd_A); end
        tick();
        checks++; if (pend_A !== 1'b0) begin errors++; $display("FAIL fwd_zero_retired got %b exp 0", pend_A); end
    endtask

    task automatic test_reset_mid_drain;
        ld_valid = 1'b1;  ld_addr = 5'd4;  ld_data = 32'h11;
        fpu_valid = 1'b1; fpu_addr = 5'd6; fpu_data = 32'h22;
        tick();
        ld_data = 32'h33; fpu_data = 32'h44;
        tick();
        ld_valid = 1'b0; fpu_valid = 1'b0;
        addr_A = 5'd4; addr_B = 5'd6;
        #1;
        checks++; if (count !== 3'd3 || pend_A !== 1'b1) begin errors++; $display("FAIL rst_setup got %0d %b exp 3 1", count, pend_A); end
        #1;
        Rst = 1'b1;
        #1;
        checks++; if (write_En !== 1'b0 || count !== 3'd0) begin errors++; $display("FAIL rst_async got %b %0d exp 0 0", write_En, count); end
        checks++; if (pend_A !== 1'b0 || pend_B !== 1'b0 || fwd_A !== 32'h0 || fwd_B !== 32'h0)
            begin errors++; $display("FAIL rst_lookup got %b%b %h %h exp 00 0 0", pend_A, pend_B, fwd_A, fwd_B); end
        checks++; if (ld_ready !== 1'b1 || fpu_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b%b exp 11", ld_ready, fpu_ready); end
        tick();
        Rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (write_En !== 1'b0 || count !== 3'd0)
                begin errors++; $display("FAIL rst_stale[%0d] got %b %0d exp 0 0", k, write_En, count); end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        Rst = 1'b1;
        ld_valid = 1'b0;  ld_addr = '0;  ld_data = '0;
        fpu_valid = 1'b0; fpu_addr = '0; fpu_data = '0;
        addr_A = 5'd5; addr_B = 5'd9;
        test_reset();
        test_single_load();
        test_dual_push();
        test_fill();
        test_forward();
        test_reset_mid_drain();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule

// File: doc/fp_wb_queue.md
FP_WB_QUEUE -- requirements
Module: fp_wb_queue

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of FP result data.
REQ-002 Parameter ADDR_WIDTH, default 5, FP register index width.
REQ-003 Parameter DEPTH, default 4, queue entries; SHALL be a power of two, at least 2.
REQ-004 Clk  input  1  single clock; all state updates on rising edge.
REQ-005 Rst  input  1  reset, asynchronous, active-high.
REQ-006 ld_valid  input  1  FP-load result offered.
REQ-007 ld_addr  input  ADDR_WIDTH  FP-load destination register.
REQ-008 ld_data  input  DATA_WIDTH  FP-load result.
REQ-009 ld_ready  output  1  queue accepts FP-load result this cycle.
REQ-010 fpu_valid / fpu_addr / fpu_data / fpu_ready  same widths and directions as the ld_* ports, for the FPU result source.
REQ-011 write_En  output  1  register-file write enable.
REQ-012 writeAddr  output  ADDR_WIDTH  register-file write index.
REQ-013 data_in  output  DATA_WIDTH  register-file write data.
REQ-014 addr_A, addr_B  input  ADDR_WIDTH  read-port indices to be checked against queued writes.
REQ-015 pend_A, pend_B  output  1  a queued, not yet retired write targets addr_A / addr_B.
REQ-016 fwd_A, fwd_B  output  DATA_WIDTH  data of the youngest queued entry matching addr_A / addr_B; zero when there is no match.
REQ-017 count  output  $clog2(DEPTH)+1  number of occupied entries.

Function
REQ-018 Circular FIFO of {addr, data}; head = oldest entry.
REQ-019 write_En = (count != 0); writeAddr and data_in = head entry; all three are combinational from state.
REQ-020 When count != 0, the head pops on every rising edge (the register file always accepts).
REQ-021 free = DEPTH - count + (count != 0 ? 1 : 0), i.e. pop-this-cycle credit included.
REQ-022 ld_ready = (free >= 1); ld_ready is independent of any valid input.
REQ-023 fpu_ready = (free >= 2) OR (free >= 1 AND NOT ld_valid); FP load has fixed priority.
REQ-024 Push occurs on (valid AND ready) per source; both sources may push in the same cycle.
REQ-025 On a dual push, the load entry is enqueued before the FPU entry (load is older).
REQ-026 count_next = count + pushes - pop; pointers wrap modulo DEPTH.
REQ-027 Latency: a result accepted at edge N drives write_En in the cycle after edge N only if the queue is empty before edge N; otherwise it drives write_En after all older entries have popped.
REQ-028 Overflow is impossible by REQ-022/023; an empty-queue pop is suppressed.
REQ-029 pend_X/fwd_X compare addr_X against every occupied entry, including the head; the youngest match wins; no address is treated as hardwired zero.
REQ-030 The same address may appear in multiple entries; retirement order = enqueue order, so the last write wins in the register file.
REQ-031 Starvation of the FPU under continuous load traffic is permitted; the upstream pipeline guarantees bounded load bursts.

Reset
REQ-032 Rst high SHALL immediately clear all pointers and count; write_En, pend_A and pend_B go 0; fwd_A and fwd_B go 0; ld_ready and fpu_ready go 1.
REQ-033 Entries in flight when Rst asserts are discarded, and no partial write is issued.
REQ-034 Entry data storage need not be reset; outputs SHALL not expose it while count = 0.

Structure
REQ-035 The shared FP package holds ADDR_WIDTH, DATA_WIDTH and the {addr, data} entry typedef.
REQ-036 Sub-module fp_wb_match SHALL implement the youngest-match search and SHALL be instantiated once per read port.
REQ-037 The FIFO is implemented inline; no sub-module is used for it.

Verification
REQ-038 Single load at an empty queue: ld addr=3, data=0x3F800000 at edge N -> write_En=1, writeAddr=3, data_in=0x3F800000 for exactly one cycle after edge N.
REQ-039 Dual push at an empty queue: ld(1, 0xA) and fpu(2, 0xB) -> writes (1, 0xA) then (2, 0xB) on consecutive cycles; count sequence 2, 1, 0.
REQ-040 Fill: both sources valid every cycle, DEPTH=4 -> count saturates at 4; with free=1, ld_ready=1 and fpu_ready=0; no entry is lost or duplicated.
REQ-041 Forwarding: queue holds (5, 0x1), (7, 0x2), (5, 0x3); addr_A=5 -> pend_A=1, fwd_A=0x3; addr_B=9 -> pend_B=0, fwd_B=0.
REQ-042 Reset mid-drain: Rst pulsed with count=3 -> write_En, count and pend_A/pend_B all 0 before the next edge; after release, no stale write appears.
